store_wb_buffer: RTL and testbench

Post-retirement store write buffer that sits directly downstream of the store queue (`sq`). It accepts up to three retired stores per cycle on the SQ's `cache_wb` lanes and holds them in an 8-entry circular FIFO. It coalesces stores to the same word and drains them one per handshake to the data cache. It also provides byte-granular load forwarding, because retired stores have already left the SQ but are not yet in the cache.

---
 rtl/store_wb_buffer.sv | 170 +++++++++++++++++
 tb/tb_store_wb_buffer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/store_wb_buffer.sv
// store_wb_buffer: post-retirement store write buffer between the store queue
// and the data cache. It holds retired stores in a circular FIFO, coalesces
// same-word stores into the youngest non-head entry, drains one entry per
// dcache handshake and forwards bytes to loads.
//
// cache_wb packs RETIRE_WIDTH lanes of PKT_W bits; lane i is at
// cache_wb[i*PKT_W +: PKT_W], laid out as {addr[31:0], usebytes[3:0],
// data[31:0], ready}. retire_store qualifies each lane, so the ready bit and
// addr[1:0] do not affect the buffer.
module store_wb_buffer #(
  parameter int DEPTH        = 8,
  parameter int RETIRE_WIDTH = 3,
  localparam int PKT_W       = 69
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [RETIRE_WIDTH-1:0]       retire_store,
  input  logic [RETIRE_WIDTH*PKT_W-1:0] cache_wb,
  output logic [$clog2(DEPTH):0]        wb_free_num,
  output logic                          wb_empty,
  output logic                          wb_overflow,
  output logic                          dc_req_valid,
  output logic [31:0]                   dc_req_addr,
  output logic [31:0]                   dc_req_data,
  output logic [3:0]                    dc_req_bytes,
  input  logic                          dc_req_ready,
  input  logic [31:0]                   ld_addr,
  output logic [3:0]                    ld_fwd_bytes,
  output logic [31:0]                   ld_fwd_data
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  // Registered entry storage and pointers
  logic          ent_valid [DEPTH];
  logic [29:0]   ent_waddr [DEPTH];
  logic [3:0]    ent_bytes [DEPTH];
  logic [31:0]   ent_data  [DEPTH];
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [PW:0]   count_q;
  logic          ovf_q;
  logic [PW:0]   free_q;
  logic          empty_q;

  // Next-state values
  logic          n_valid [DEPTH];
  logic [29:0]   n_waddr [DEPTH];
  logic [3:0]    n_bytes [DEPTH];
  logic [31:0]   n_data  [DEPTH];
  logic [PW-1:0] n_head;
  logic [PW-1:0] n_tail;
  logic [PW:0]   n_count;
  logic          n_ovf;

  // Per-lane scratch for the enqueue loop
  logic [PKT_W-1:0] pkt;
  logic [29:0]      in_waddr;
  logic [3:0]       in_bytes;
  logic [31:0]      in_data;
  logic [PW-1:0]    youngest;
  logic [PW-1:0]    fwd_idx;

  assign wb_free_num  = free_q;
  assign wb_empty     = empty_q;
  assign wb_overflow  = ovf_q;
  assign dc_req_valid = !empty_q;
  assign dc_req_addr  = {ent_waddr[head_q], 2'b00};
  assign dc_req_data  = ent_data[head_q];
  assign dc_req_bytes = ent_bytes[head_q];

  // Enqueue lanes oldest-first (each lane sees earlier lanes' effect), then dequeue
  always_comb begin
    n_valid  = ent_valid;
    n_waddr  = ent_waddr;
    n_bytes  = ent_bytes;
    n_data   = ent_data;
    n_head   = head_q;
    n_tail   = tail_q;
    n_count  = count_q;
    n_ovf    = ovf_q;
    pkt      = '0;
    in_waddr = '0;
    in_bytes = '0;
    in_data  = '0;
    youngest = '0;
    for (int unsigned k = 0; k < RETIRE_WIDTH; k++) begin
      pkt      = cache_wb[(RETIRE_WIDTH-1-k)*PKT_W +: PKT_W];
      in_waddr = pkt[68:39];
      in_bytes = pkt[36:33];
      in_data  = pkt[32:1];
      youngest = n_tail - PW'(1);
      if (retire_store[RETIRE_WIDTH-1-k]) begin
        if (n_count != '0 && youngest != head_q && n_waddr[youngest] == in_waddr) begin
          for (int unsigned b = 0; b < 4; b++) begin
            if (in_bytes[b]) n_data[youngest][8*b +: 8] = in_data[8*b +: 8];
          end
          n_bytes[youngest] = n_bytes[youngest] | in_bytes;
        end else if (n_count == FULL_CNT) begin
          n_ovf = 1'b1;
        end else begin
          n_valid[n_tail] = 1'b1;
          n_waddr[n_tail] = in_waddr;
          n_bytes[n_tail] = in_bytes;
          for (int unsigned b = 0; b < 4; b++) begin
            n_data[n_tail][8*b +: 8] = in_bytes[b] ? in_data[8*b +: 8] : 8'h00;
          end
          n_tail  = n_tail + PW'(1);
          n_count = n_count + (PW+1)'(1);
        end
      end
    end
    // The full check above uses the pre-dequeue count, so a slot freed by
    // this cycle's dequeue is only reusable next cycle.
    if (dc_req_valid && dc_req_ready) begin
      n_valid[head_q] = 1'b0;
      n_head          = head_q + PW'(1);
      n_count         = n_count - (PW+1)'(1);
    end
  end

  // Byte-granular forwarding, oldest to youngest so younger bytes overwrite
  always_comb begin
    ld_fwd_bytes = '0;
    ld_fwd_data  = '0;
    fwd_idx      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PW'(i);
      if (ent_valid[fwd_idx] && ent_waddr[fwd_idx] == ld_addr[31:2]) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (ent_bytes[fwd_idx][b]) begin
            ld_fwd_bytes[b]         = 1'b1;
            ld_fwd_data[8*b +: 8]   = ent_data[fwd_idx][8*b +: 8];
          end
        end
      end
    end
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_valid[i] <= 1'b0;
        ent_waddr[i] <= '0;
        ent_bytes[i] <= '0;
        ent_data[i]  <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      free_q  <= FULL_CNT;
      empty_q <= 1'b1;
    end else begin
      ent_valid <= n_valid;
      ent_waddr <= n_waddr;
      ent_bytes <= n_bytes;
      ent_data  <= n_data;
      head_q    <= n_head;
      tail_q    <= n_tail;
      count_q   <= n_count;
      ovf_q     <= n_ovf;
      free_q    <= FULL_CNT - n_count;
      empty_q   <= (n_count == '0);
    end
  end

endmodule

// File: tb/tb_store_wb_buffer.sv
// tb_store_wb_buffer: scoreboard bench for store_wb_buffer. Expected drain
// requests are queued as stores are retired and popped as the dcache accepts.
module tb_store_wb_buffer;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  bytes;
    logic [31:0] data;
  } req_t;

  logic         clock;
  logic         reset;
  logic [2:0]   retire_store;
  logic [206:0] cache_wb;
  logic [3:0]   wb_free_num;
  logic         wb_empty;
  logic         wb_overflow;
  logic         dc_req_valid;
  logic [31:0]  dc_req_addr;
  logic [31:0]  dc_req_data;
  logic [3:0]   dc_req_bytes;
  logic         dc_req_ready;
  logic [31:0]  ld_addr;
  logic [3:0]   ld_fwd_bytes;
  logic [31:0]  ld_fwd_data;

  int   n_checks;
  int   n_fail;
  req_t sb[$];

  store_wb_buffer #(.DEPTH(8), .RETIRE_WIDTH(3)) dut (
    .clock        (clock),
    .reset        (reset),
    .retire_store (retire_store),
    .cache_wb     (cache_wb),
    .wb_free_num  (wb_free_num),
    .wb_empty     (wb_empty),
    .wb_overflow  (wb_overflow),
    .dc_req_valid (dc_req_valid),
    .dc_req_addr  (dc_req_addr),
    .dc_req_data  (dc_req_data),
    .dc_req_bytes (dc_req_bytes),
    .dc_req_ready (dc_req_ready),
    .ld_addr      (ld_addr),
    .ld_fwd_bytes (ld_fwd_bytes),
    .ld_fwd_data  (ld_fwd_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_lane(input int l, input logic [31:0] a, input logic [3:0] ub,
                          input logic [31:0] d);
    cache_wb[l*69 +: 69] = {a, ub, d, 1'b1};
    retire_store[l]      = 1'b1;
  endtask

  task automatic exp_push(input logic [31:0] a, input logic [3:0] ub, input logic [31:0] d);
    req_t r;
    r.addr  = {a[31:2], 2'b00};
    r.bytes = ub;
    r.data  = d;
    sb.push_back(r);
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clock);
    #1;
    retire_store = '0;
  endtask

  task automatic fwd(input logic [31:0] a, input logic [3:0] eb, input logic [31:0] ed);
    ld_addr = a;
    #1;
    check("fwd_bytes", 32'(ld_fwd_bytes), 32'(eb));
    check("fwd_data", ld_fwd_data, ed);
  endtask

  // Drain with ready held high; every presented request is checked before acceptance
  task automatic drain(input int max_cyc, output int cyc);
    req_t r;
    cyc = 0;
    dc_req_ready = 1'b1;
    while (dc_req_valid && cyc < max_cyc) begin
      if (sb.size() == 0) begin
        check("drain_extra", 32'(dc_req_valid), 32'd0);
      end else begin
        r = sb.pop_front();
        check("drain_addr", dc_req_addr, r.addr);
        check("drain_bytes", 32'(dc_req_bytes), 32'(r.bytes));
        check("drain_data", dc_req_data, r.data);
      end
      @(posedge clock);
      #1;
      cyc++;
    end
    dc_req_ready = 1'b0;
    check("drain_timeout", 32'(dc_req_valid), 32'd0);
    check("sb_left", 32'(sb.size()), 32'd0);
    check("drain_empty", 32'(wb_empty), 32'd1);
    check("drain_free", 32'(wb_free_num), 32'd8);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    req_t r;
    n_checks = 0;
    n_fail   = 0;
    reset        = 1'b0;
    retire_store = '0;
    cache_wb     = '0;
    dc_req_ready = 1'b0;
    ld_addr      = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("rst_free", 32'(wb_free_num), 32'd8);
    check("rst_empty", 32'(wb_empty), 32'd1);
    check("rst_valid", 32'(dc_req_valid), 32'd0);
    check("rst_ovf", 32'(wb_overflow), 32'd0);
    check("rst_fwd", 32'(ld_fwd_bytes), 32'd0);

    // Ordered drain: three lanes in one cycle
    @(posedge clock); #1;
    set_lane(2, 32'hC0, 4'hF, 32'h0000000A); exp_push(32'hC0, 4'hF, 32'h0000000A);
    set_lane(1, 32'hC4, 4'hF, 32'h0000000B); exp_push(32'hC4, 4'hF, 32'h0000000B);
    set_lane(0, 32'hC8, 4'hF, 32'h0000000C); exp_push(32'hC8, 4'hF, 32'h0000000C);
    tick();
    check("ord_free", 32'(wb_free_num), 32'd5);
    check("ord_valid", 32'(dc_req_valid), 32'd1);
    drain(20, cyc);
    check("ord_cycles", 32'(cyc), 32'd3);

    // Coalescing: head lock forces allocation, then merge into entry 1
    set_lane(2, 32'hC0, 4'b0011, 32'h00002345); tick();
    check("co_free1", 32'(wb_free_num), 32'd7);
    set_lane(2, 32'hC0, 4'b0100, 32'h00650000); tick();
    check("co_free2", 32'(wb_free_num), 32'd6);
    set_lane(2, 32'hC0, 4'b1000, 32'h87000000); tick();
    check("co_free3", 32'(wb_free_num), 32'd6);
    fwd(32'hC0, 4'hF, 32'h87652345);
    fwd(32'hC3, 4'hF, 32'h87652345);
    fwd(32'hC4, 4'h0, 32'h0);
    exp_push(32'hC0, 4'b0011, 32'h00002345);
    exp_push(32'hC0, 4'b1100, 32'h87650000);
    drain(20, cyc);

    // Head lock with a single entry: no merge into the presented head
    set_lane(1, 32'hC0, 4'hF, 32'h11111111); tick();
    check("hl_free1", 32'(wb_free_num), 32'd7);
    set_lane(0, 32'hC0, 4'b0001, 32'h000000AA); tick();
    check("hl_free2", 32'(wb_free_num), 32'd6);
    check("hl_head_data", dc_req_data, 32'h11111111);
    check("hl_head_bytes", 32'(dc_req_bytes), 32'hF);
    fwd(32'hC0, 4'hF, 32'h111111AA);
    exp_push(32'hC0, 4'hF, 32'h11111111);
    exp_push(32'hC0, 4'b0001, 32'h000000AA);
    drain(20, cyc);

    // Same-cycle lanes: lane 1 merges into the entry lane 2 just allocated
    set_lane(2, 32'h300, 4'hF, 32'h30303030); tick();
    set_lane(2, 32'h304, 4'b0011, 32'h0000BBAA);
    set_lane(1, 32'h304, 4'b1100, 32'hDDCC0000);
    set_lane(0, 32'h308, 4'hF, 32'h12345678);
    tick();
    check("ic_free", 32'(wb_free_num), 32'd5);
    fwd(32'h304, 4'hF, 32'hDDCCBBAA);
    exp_push(32'h300, 4'hF, 32'h30303030);
    exp_push(32'h304, 4'hF, 32'hDDCCBBAA);
    exp_push(32'h308, 4'hF, 32'h12345678);
    drain(20, cyc);

    // Full and overflow
    for (int i = 0; i < 8; i++) begin
      set_lane(2 - (i % 3), 32'h100 + 32'(4*i), 4'hF, 32'hA0000000 + 32'(i));
      exp_push(32'h100 + 32'(4*i), 4'hF, 32'hA0000000 + 32'(i));
      if (i % 3 == 2 || i == 7) tick();
    end
    check("full_free", 32'(wb_free_num), 32'd0);
    check("full_ovf0", 32'(wb_overflow), 32'd0);
    set_lane(2, 32'h200, 4'hF, 32'hDEADBEEF); tick();
    check("ovf_free", 32'(wb_free_num), 32'd0);
    check("ovf_flag", 32'(wb_overflow), 32'd1);
    check("ovf_head", dc_req_addr, 32'h100);
    fwd(32'h11C, 4'hF, 32'hA0000007);
    fwd(32'h200, 4'h0, 32'h0);
    drain(20, cyc);
    check("full_cycles", 32'(cyc), 32'd8);
    check("ovf_sticky", 32'(wb_overflow), 32'd1);

    // Asynchronous reset with five entries and a request outstanding
    for (int i = 0; i < 5; i++) begin
      set_lane(2 - (i % 3), 32'h400 + 32'(4*i), 4'hF, 32'h40 + 32'(i));
      if (i % 3 == 2 || i == 4) tick();
    end
    check("pre_rst_free", 32'(wb_free_num), 32'd3);
    check("pre_rst_valid", 32'(dc_req_valid), 32'd1);
    ld_addr = 32'h400;
    #2;
    reset = 1'b0;
    #1;
    check("arst_valid", 32'(dc_req_valid), 32'd0);
    check("arst_fwd", 32'(ld_fwd_bytes), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    tick();
    check("rel_free", 32'(wb_free_num), 32'd8);
    check("rel_empty", 32'(wb_empty), 32'd1);
    check("rel_valid", 32'(dc_req_valid), 32'd0);
    check("rel_ovf", 32'(wb_overflow), 32'd0);

    // Simultaneous enqueue and dequeue at seven entries
    for (int i = 0; i < 7; i++) begin
      set_lane(2 - (i % 3), 32'h500 + 32'(4*i), 4'hF, 32'hB0 + 32'(i));
      exp_push(32'h500 + 32'(4*i), 4'hF, 32'hB0 + 32'(i));
      if (i % 3 == 2 || i == 6) tick();
    end
    check("sim_free0", 32'(wb_free_num), 32'd1);
    set_lane(2, 32'h600, 4'hF, 32'h66666666);
    set_lane(1, 32'h604, 4'hF, 32'h77777777);
    dc_req_ready = 1'b1;
    r = sb.pop_front();
    check("sim_acc_addr", dc_req_addr, r.addr);
    tick();
    dc_req_ready = 1'b0;
    exp_push(32'h600, 4'hF, 32'h66666666);
    check("sim_free1", 32'(wb_free_num), 32'd1);
    check("sim_ovf", 32'(wb_overflow), 32'd1);
    fwd(32'h600, 4'hF, 32'h66666666);
    fwd(32'h604, 4'h0, 32'h0);
    drain(20, cyc);
    check("sim_cycles", 32'(cyc), 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
